xoodyak_loader: RTL and testbench
=================================

Name: xoodyak_loader

Overview:
Upstream feeder for the xoodyak core. It accepts a narrow word stream over a valid/ready handshake and assembles key, nonce, associated data, text and (for decrypt) verification data into the core's wide operand ports. Once the operands are complete it issues a one-cycle start pulse, then holds the operands stable until the core reports completion. One instance sits in front of each xoodyak core (encrypt and decrypt).

Parameters:
WORD_W, 32, input word width; must divide 128 and 192; only 32 is supported.
TIMEOUT_CYCLES, 64, watchdog limit in WAIT; used only with the optional feature.

Ports:
eph1  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
ld_start  in  1  pulse: begin a load; sampled only in IDLE.
ld_opmode  in  1  0 = encrypt, 1 = decrypt; latched with ld_start.
in_valid  in  1  in_data valid.
in_data  in  WORD_W  operand word.
in_ready  out  1  loader accepts a word this cycle.
core_done  in  1  core completion; connects to the core's sqzdone.
key  out  128  to core key.
nonce  out  128  to core nonce.
assodata  out  128  to core assodata.
textin  out  192  to core textin.
verification_data  out  128  to core verification_data.
opmode  out  1  to core opmode.
start  out  1  to core start, one-cycle pulse.
busy  out  1  high from ld_start acceptance until return to IDLE.
timeout  out  1  sticky watchdog flag; present only with the optional feature.

Behaviour:
- Reset, applied asynchronously: FSM goes to IDLE; word counter = 0; all field registers = 0; opmode, start, in_ready, busy and timeout = 0.
- FSM states: IDLE, LOAD, FIRE, WAIT.
- IDLE -> LOAD when ld_start = 1:
  - latch ld_opmode into opmode;
  - clear the word counter and all field registers;
  - busy goes high the next cycle.
  - ld_start in any other state is ignored.
- LOAD:
  - in_ready = 1; a word is accepted on in_valid & in_ready.
  - Counter cnt (5 bits) advances only on acceptance.
  - Word order, fields filled in sequence, least-significant word first:
    - key: words 0-3 (word 0 -> key[31:0]);
    - nonce: words 4-7;
    - assodata: words 8-11;
    - textin: words 12-17 (word 12 -> textin[31:0]);
    - verification_data: words 18-21, only when opmode = 1.
  - Total N = 18 words for encrypt, 22 for decrypt.
  - Acceptance of word N-1 -> FIRE. in_ready drops in the same cycle FIRE is entered.
  - in_valid with in_ready = 0 is never consumed.
- FIRE: start = 1 for exactly one cycle, then -> WAIT.
- WAIT:
  - in_ready = 0; all operand outputs held stable.
  - core_done = 1 -> IDLE; busy drops the cycle after.
  - core_done sampled in any other state is ignored.
- Latency: start asserts 1 cycle after the last word is accepted.
  - Back-to-back ops: earliest ld_start acceptance is the cycle after core_done.
- Operands retain their last values in IDLE; they are cleared only by reset or the next ld_start.
- Reset mid-LOAD or mid-WAIT: immediate return to IDLE, no start pulse, partial operands discarded.
- Simultaneous core_done and FIRE cannot happen legally; if it occurs, FIRE still proceeds to WAIT.

Optional Feature:
XOODYAK_LOADER_TIMEOUT_EN
- Defined:
  - a counter runs in WAIT;
  - if core_done has not arrived after TIMEOUT_CYCLES cycles, set timeout (sticky until reset or next accepted ld_start) and go to IDLE;
  - the timeout port exists.
- Undefined: no counter and no timeout port; WAIT waits indefinitely.

Decomposition:
- Shared package xoodyak_pkg holds:
  - loader_state_t enum {IDLE, LOAD, FIRE, WAIT};
  - constants KEY_WORDS = 4, NONCE_WORDS = 4, AD_WORDS = 4, TEXT_WORDS = 6, VERIF_WORDS = 4;
  - constants ENC_WORDS = 18, DEC_WORDS = 22.
- One natural sub-module: xoodyak_loader_wdt, the watchdog counter, instantiated only under the macro.
- Field registers use the codebase's existing enable-register library cells.

Test Plan:
- Encrypt load: ld_start with ld_opmode = 0, then 18 words of the ASCII key "0123456789:;<=>?", nonce "ABCDEFGHIJKLMNOP", AD "abcdefghijklmnop", text "ABCD…WX" -> key = 128'h38393a3b3c3d3e3f3031323334353637, textin = 192'h4d4e…4a4b4c, one-cycle start 1 cycle after word 17, verification_data = 0.
- Decrypt load: ld_opmode = 1, 22 words with verification words 32'h11111111..44444444 -> verification_data = 128'h44444444333333332222222211111111, start after word 21, opmode = 1.
- Backpressure: toggle in_valid randomly during LOAD -> field contents identical to the gap-free case; ld_start pulses mid-LOAD have no effect.
- Completion: core_done 10 cycles after start -> busy falls the next cycle; a new ld_start one cycle later is accepted.
- Reset mid-LOAD after word 7 -> all outputs 0, no start pulse; a subsequent full load succeeds.
- With XOODYAK_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES = 8: withhold core_done -> timeout = 1 and return to IDLE 8 cycles after WAIT entry; next ld_start clears timeout.

Source files
------------

// File: rtl/xoodyak_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xoodyak_pkg
// Purpose  : Shared types and word-count constants for the xoodyak loader.
// Revision : 1.0 - initial release
// ============================================================================
package xoodyak_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FIRE = 2'd2,
        WAIT = 2'd3
    } loader_state_t;

    localparam int KEY_WORDS   = 4;
    localparam int NONCE_WORDS = 4;
    localparam int AD_WORDS    = 4;
    localparam int TEXT_WORDS  = 6;
    localparam int VERIF_WORDS = 4;

    localparam int ENC_WORDS = KEY_WORDS + NONCE_WORDS + AD_WORDS + TEXT_WORDS;
    localparam int DEC_WORDS = ENC_WORDS + VERIF_WORDS;

    // Stream index of the first word of each field.
    localparam int KEY_BASE   = 0;
    localparam int NONCE_BASE = KEY_BASE + KEY_WORDS;
    localparam int AD_BASE    = NONCE_BASE + NONCE_WORDS;
    localparam int TEXT_BASE  = AD_BASE + AD_WORDS;
    localparam int VERIF_BASE = TEXT_BASE + TEXT_WORDS;

endpackage : xoodyak_pkg
`default_nettype wire

// File: rtl/xoodyak_loader_wdt.sv
`default_nettype none
// ============================================================================
// Module   : xoodyak_loader_wdt
// Purpose  : WAIT-state watchdog; flags a core that never reports completion.
// Revision : 1.0 - initial release
// ============================================================================
module xoodyak_loader_wdt #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic eph1,
    input  logic reset,
    input  logic run,
    input  logic done,
    input  logic clear,
    output logic expire,
    output logic timeout
);

    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_CNT_W-1:0] r_count;
    logic               r_timeout;

    // A completion arriving on the last allowed cycle takes precedence.
    assign expire  = run && !done && (r_count == c_CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout = r_timeout;

    always_ff @(posedge eph1 or posedge reset) begin
        if (reset) begin
            r_count   <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (run) begin
                r_count <= r_count + 1'b1;
            end else begin
                r_count <= '0;
            end
            if (clear) begin
                r_timeout <= 1'b0;
            end else if (expire) begin
                r_timeout <= 1'b1;
            end
        end
    end

endmodule : xoodyak_loader_wdt
`default_nettype wire

// File: rtl/xoodyak_loader.sv
`default_nettype none
// ============================================================================
// Module   : xoodyak_loader
// Purpose  : Assembles a 32-bit word stream into xoodyak core operands and
//            issues a one-cycle start. Optional WAIT watchdog under macro
//            XOODYAK_LOADER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module xoodyak_loader
    import xoodyak_pkg::*;
#(
    parameter int WORD_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              eph1,
    input  logic              reset,
    input  logic              ld_start,
    input  logic              ld_opmode,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    input  logic              core_done,
    output logic [127:0]      key,
    output logic [127:0]      nonce,
    output logic [127:0]      assodata,
    output logic [191:0]      textin,
    output logic [127:0]      verification_data,
    output logic              opmode,
    output logic              start,
`ifdef XOODYAK_LOADER_TIMEOUT_EN
    output logic              timeout,
`endif
    output logic              busy
);

    loader_state_t r_state;
    loader_state_t w_state_nxt;

    logic [4:0]   r_cnt;
    logic [127:0] r_key;
    logic [127:0] r_nonce;
    logic [127:0] r_ad;
    logic [191:0] r_text;
    logic [127:0] r_verif;
    logic         r_opmode;

    logic w_load_go;
    logic w_accept;
    logic w_last;
    logic w_expire;

    assign w_load_go = (r_state == IDLE) && ld_start;
    assign w_accept  = (r_state == LOAD) && in_valid;
    assign w_last    = (r_cnt == (r_opmode ? 5'(DEC_WORDS - 1) : 5'(ENC_WORDS - 1)));

`ifdef XOODYAK_LOADER_TIMEOUT_EN
    xoodyak_loader_wdt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdt (
        .eph1    (eph1),
        .reset   (reset),
        .run     (r_state == WAIT),
        .done    (core_done),
        .clear   (w_load_go),
        .expire  (w_expire),
        .timeout (timeout)
    );
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge eph1 or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (ld_start) w_state_nxt = LOAD;
            LOAD: if (w_accept && w_last) w_state_nxt = FIRE;
            FIRE: w_state_nxt = WAIT;
            WAIT: if (core_done || w_expire) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge eph1 or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_load_go) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Each accepted word lands in the slot selected by the stream index.
    always_ff @(posedge eph1 or posedge reset) begin
        if (reset) begin
            r_key    <= '0;
            r_nonce  <= '0;
            r_ad     <= '0;
            r_text   <= '0;
            r_verif  <= '0;
            r_opmode <= 1'b0;
        end else if (w_load_go) begin
            r_key    <= '0;
            r_nonce  <= '0;
            r_ad     <= '0;
            r_text   <= '0;
            r_verif  <= '0;
            r_opmode <= ld_opmode;
        end else if (w_accept) begin
            for (int i = 0; i < KEY_WORDS; i++) begin
                if (r_cnt == 5'(KEY_BASE + i)) r_key[i*WORD_W +: WORD_W] <= in_data;
            end
            for (int i = 0; i < NONCE_WORDS; i++) begin
                if (r_cnt == 5'(NONCE_BASE + i)) r_nonce[i*WORD_W +: WORD_W] <= in_data;
            end
            for (int i = 0; i < AD_WORDS; i++) begin
                if (r_cnt == 5'(AD_BASE + i)) r_ad[i*WORD_W +: WORD_W] <= in_data;
            end
            for (int i = 0; i < TEXT_WORDS; i++) begin
                if (r_cnt == 5'(TEXT_BASE + i)) r_text[i*WORD_W +: WORD_W] <= in_data;
            end
            for (int i = 0; i < VERIF_WORDS; i++) begin
                if (r_opmode && (r_cnt == 5'(VERIF_BASE + i))) begin
                    r_verif[i*WORD_W +: WORD_W] <= in_data;
                end
            end
        end
    end

    assign in_ready          = (r_state == LOAD);
    assign start             = (r_state == FIRE);
    assign busy              = (r_state != IDLE);
    assign key               = r_key;
    assign nonce             = r_nonce;
    assign assodata          = r_ad;
    assign textin            = r_text;
    assign verification_data = r_verif;
    assign opmode            = r_opmode;

endmodule : xoodyak_loader
`default_nettype wire

// File: tb/tb_xoodyak_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_xoodyak_loader
// Purpose  : Scoreboard bench for xoodyak_loader; timeout checks run when
//            XOODYAK_LOADER_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xoodyak_loader;

`ifdef XOODYAK_LOADER_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
    localparam int DONE_DLY   = 5;
`else
    localparam int TB_TIMEOUT = 64;
    localparam int DONE_DLY   = 10;
`endif

    logic         eph1      = 1'b0;
    logic         reset     = 1'b1;
    logic         ld_start  = 1'b0;
    logic         ld_opmode = 1'b0;
    logic         in_valid  = 1'b0;
    logic [31:0]  in_data   = '0;
    logic         core_done = 1'b0;
    logic         in_ready;
    logic [127:0] key, nonce, assodata, verification_data;
    logic [191:0] textin;
    logic         opmode, start, busy;
`ifdef XOODYAK_LOADER_TIMEOUT_EN
    logic         timeout;
`endif

    xoodyak_loader #(
        .WORD_W         (32),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .eph1              (eph1),
        .reset             (reset),
        .ld_start          (ld_start),
        .ld_opmode         (ld_opmode),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_ready          (in_ready),
        .core_done         (core_done),
        .key               (key),
        .nonce             (nonce),
        .assodata          (assodata),
        .textin            (textin),
        .verification_data (verification_data),
        .opmode            (opmode),
        .start             (start),
`ifdef XOODYAK_LOADER_TIMEOUT_EN
        .timeout           (timeout),
`endif
        .busy              (busy)
    );

    always #5 eph1 = ~eph1;

    int cyc = 0;
    always @(posedge eph1) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] key;
        logic [127:0] nonce;
        logic [127:0] ad;
        logic [191:0] text;
        logic [127:0] verif;
        logic         op;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_cmp    = 0;
    int   n_fail   = 0;
    int   last_acc = -100;
    logic prev_start = 1'b0;
    logic [31:0] w [22];

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference: each field is its words laid out least-significant first.
    function automatic exp_t model(input logic op, input logic [31:0] wv [22]);
        exp_t e;
        e.key = '0; e.nonce = '0; e.ad = '0; e.text = '0; e.verif = '0; e.op = op;
        for (int i = 0; i < 4; i++) begin
            e.key[32*i +: 32]   = wv[i];
            e.nonce[32*i +: 32] = wv[4+i];
            e.ad[32*i +: 32]    = wv[8+i];
            if (op) e.verif[32*i +: 32] = wv[18+i];
        end
        for (int i = 0; i < 6; i++) e.text[32*i +: 32] = wv[12+i];
        return e;
    endfunction

    function automatic logic [31:0] asc4(input logic [7:0] c);
        return {c, c + 8'd1, c + 8'd2, c + 8'd3};
    endfunction

    // Monitor: every start pulse pops one expected operand set.
    always @(negedge eph1) begin
        exp_t e;
        if (reset) begin
            prev_start = 1'b0;
        end else begin
            if (start) begin
                chk("start_width", prev_start, 1'b0);
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_start: got start=1, expected no pulse (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("key",      key,               e.key);
                    chk("nonce",    nonce,             e.nonce);
                    chk("assodata", assodata,          e.ad);
                    chk("textin",   textin,            e.text);
                    chk("verif",    verification_data, e.verif);
                    chk("opmode",   opmode,            e.op);
                    chk("start_latency", cyc, last_acc + 1);
                end
            end
            prev_start = start;
        end
    end

    task automatic send_word(input logic [31:0] wd, input bit gaps);
        int guard = 0;
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                in_valid  = 1'b0;
                in_data   = $urandom;
                ld_start  = 1'($urandom_range(0, 1));
                ld_opmode = 1'($urandom_range(0, 1));
                core_done = 1'($urandom_range(0, 1));
                @(posedge eph1); #1;
            end
        end
        ld_start  = 1'b0;
        core_done = 1'b0;
        in_valid  = 1'b1;
        in_data   = wd;
        while (!in_ready && guard < 50) begin
            @(posedge eph1); #1;
            guard++;
        end
        if (!in_ready) begin
            n_cmp++; n_fail++;
            $display("FAIL in_ready_wait: got in_ready=0, expected 1 within 50 cycles");
        end
        last_acc = cyc;
        @(posedge eph1); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_load(input logic op, input bit gaps);
        exp_t e;
        e = model(op, w);
        ld_start  = 1'b1;
        ld_opmode = op;
        exp_q.push_back(e);
        cur = e;
        @(posedge eph1); #1;
        ld_start = 1'b0;
        chk("busy_after_ld_start", busy, 1'b1);
        for (int i = 0; i < (op ? 22 : 18); i++) send_word(w[i], gaps);
    endtask

    task automatic finish_op(input int dly);
        @(posedge eph1); #1;
        for (int i = 1; i < dly; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = $urandom;
            @(posedge eph1); #1;
        end
        in_valid = 1'b0;
        chk("wait_in_ready", in_ready, 1'b0);
        chk("wait_busy",     busy,     1'b1);
        chk("hold_key",      key,      cur.key);
        chk("hold_textin",   textin,   cur.text);
        chk("hold_verif",    verification_data, cur.verif);
        core_done = 1'b1;
        @(posedge eph1); #1;
        core_done = 1'b0;
        chk("busy_after_done", busy, 1'b0);
        chk("idle_keeps_nonce", nonce, cur.nonce);
    endtask

    task automatic dir_words();
        w[0] = 32'h34353637; w[1] = 32'h30313233;
        w[2] = 32'h3c3d3e3f; w[3] = 32'h38393a3b;
        for (int i = 0; i < 4; i++) begin
            w[4+i]  = asc4(8'h41 + 8'(4*i));
            w[8+i]  = asc4(8'h61 + 8'(4*i));
            w[18+i] = {4{8'(8'h11 * (i + 1))}};
        end
        for (int i = 0; i < 6; i++) w[12+i] = asc4(8'h41 + 8'(4*i));
    endtask

    task automatic rand_words();
        for (int i = 0; i < 22; i++) w[i] = $urandom;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not reach its end");
        $fatal(1, "global timeout");
    end

    initial begin
        repeat (3) @(posedge eph1);
        #1;
        chk("rst_busy",     busy,     1'b0);
        chk("rst_start",    start,    1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_key",      key,      128'h0);
        chk("rst_textin",   textin,   192'h0);
        chk("rst_opmode",   opmode,   1'b0);
        reset = 1'b0;
        @(posedge eph1); #1;

        // Directed encrypt, then back-to-back directed decrypt.
        dir_words();
        do_load(1'b0, 1'b0);
        @(negedge eph1);
        chk("enc_key_literal", key, 128'h38393a3b3c3d3e3f3031323334353637);
        @(posedge eph1); #1;
        // finish_op's first edge already passed; account for it in the delay.
        finish_op(DONE_DLY - 1);
        do_load(1'b1, 1'b0);
        finish_op(DONE_DLY);
        chk("dec_verif_literal", verification_data, 128'h44444444333333332222222211111111);
        chk("dec_opmode", opmode, 1'b1);

        // Backpressure with stray ld_start / core_done during LOAD.
        do_load(1'b0, 1'b1);
        finish_op(DONE_DLY);

        // Reset after word 7 of a load.
        rand_words();
        ld_start = 1'b1; ld_opmode = 1'b1;
        @(posedge eph1); #1;
        ld_start = 1'b0;
        for (int i = 0; i < 8; i++) send_word(w[i], 1'b0);
        reset = 1'b1;
        #2;
        chk("midrst_key",   key,   128'h0);
        chk("midrst_nonce", nonce, 128'h0);
        chk("midrst_busy",  busy,  1'b0);
        chk("midrst_opmode", opmode, 1'b0);
        @(posedge eph1); #1;
        reset = 1'b0;
        @(posedge eph1); #1;
        do_load(1'b1, 1'b1);
        finish_op(DONE_DLY);

        for (int k = 0; k < 6; k++) begin
            rand_words();
            do_load(1'($urandom_range(0, 1)), 1'b1);
            finish_op($urandom_range(1, DONE_DLY));
        end

`ifdef XOODYAK_LOADER_TIMEOUT_EN
        rand_words();
        do_load(1'b0, 1'b0);
        @(posedge eph1); #1;
        repeat (TB_TIMEOUT - 1) @(posedge eph1);
        #1;
        chk("to_busy_before",    busy,    1'b1);
        chk("to_flag_before",    timeout, 1'b0);
        @(posedge eph1); #1;
        chk("to_busy_after",     busy,    1'b0);
        chk("to_flag_after",     timeout, 1'b1);
        rand_words();
        do_load(1'b1, 1'b0);
        chk("to_cleared", timeout, 1'b0);
        finish_op(DONE_DLY);
`endif

        repeat (3) @(posedge eph1);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_xoodyak_loader
`default_nettype wire
